muldiv_sequencer: RTL

Iterative multi-cycle execution unit for the RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), sitting beside the single-cycle ALU in the datapath. Control logic issues an op with a start pulse. The datapath holds PC and register writeback while busy is high, and writes result to rd on the cycle done pulses.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 30 +++
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: op encoding (funct3),
// FSM states and a small op-class helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        logic [2:0] v;
        v = op;
        return v[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step ({hi,lo} shifts right)
// or restoring divide step ({rem,quo} shifts left, one quotient bit per call).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] trial;

    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        // Shifted partial remainder is XLEN+1 bits; a set top bit of the
        // difference means it was smaller than the divisor.
        trial    = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
        acc_next = {add_sum, acc[XLEN-1:1]};
        if (is_div) begin
            if (!trial[XLEN]) begin
                acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiplier for MUL* ops.
// Latency: XLEN+2 cycles from accepted start to done (2 cycles for MUL* when MULDIV_FAST_MUL_EN is defined).
// Backpressure: start is ignored while busy (including the done cycle) and is never queued.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e state, state_nxt;
    muldiv_op_e    op_q, op_in;

    logic [2*XLEN-1:0] acc, acc_step, mul_src, prod;
    logic [XLEN-1:0]   b_mag, a_raw, a_mag_in, b_mag_in, quo, rem, fix_val;
    logic [CW-1:0]     cnt;
    logic              sign_a, sign_b, a_neg_in, b_neg_in, a_signed, b_signed;
    logic              accept, neg_q, b_zero;

    always_comb begin
        op_in    = muldiv_op_e'(op);
        a_signed = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
        b_signed = (op_in == MULH) || (op_in == DIV) || (op_in == REM);
        a_neg_in = a_signed & dataA[XLEN-1];
        b_neg_in = b_signed & dataB[XLEN-1];
        a_mag_in = a_neg_in ? -dataA : dataA;
        b_mag_in = b_neg_in ? -dataB : dataB;
        accept   = (state == IDLE) && start && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = is_div(op_in) ? CALC : FIX;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == CW'(XLEN - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = flush ? IDLE : DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc      (acc),
        .operand  (b_mag),
        .is_div   (is_div(op_q)),
        .acc_next (acc_step)
    );

    // Magnitude results are sign-corrected here; the signed overflow case
    // (most negative / -1) falls out naturally as 0x80.. with remainder 0.
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        mul_src = {{XLEN{1'b0}}, acc[XLEN-1:0]} * {{XLEN{1'b0}}, b_mag};
`else
        mul_src = acc;
`endif
        neg_q  = sign_a ^ sign_b;
        prod   = neg_q ? -mul_src : mul_src;
        quo    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem    = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        b_zero = (b_mag == '0);
        case (op_q)
            MUL:                fix_val = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_val = prod[2*XLEN-1:XLEN];
            DIV, DIVU:          fix_val = b_zero ? '1 : quo;
            default:            fix_val = b_zero ? a_raw : rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            op_q   <= MUL;
            b_mag  <= '0;
            a_raw  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_in;
                        a_raw  <= dataA;
                        b_mag  <= b_mag_in;
                        sign_a <= a_neg_in;
                        sign_b <= b_neg_in;
                        acc    <= {{XLEN{1'b0}}, a_mag_in};
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= flush ? '0 : cnt + CW'(1);
                end
                FIX: begin
                    if (!flush) begin
                        result <= fix_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
